aes_pad_io_ctrl: RTL and testbench

//  Core-side controller between the AES core and the chip pad ring.
//  - Inbound: assembles key/plaintext bytes from the bidirectional data pads (PADDB Y) under host strobes from input pads (PADDI Y).
//  - Outbound: returns ciphertext bytes on PADDB A and owns PADDB OEN, with a guaranteed bus-turnaround gap.
//  - Raises a ready flag on an output-only pad (PADDO).

---
 rtl/aes_pad_io_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_aes_pad_io_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_pad_io_ctrl.sv
// -----------------------------------------------------------------------------
// aes_pad_io_ctrl
//
// Core-side controller sitting between the AES core and the pad ring.
//   Inbound : host writes key/plaintext bytes on the data pads (pad_y) under
//             asynchronous strobes (io_wr, io_sel). Bytes shift into key_o or
//             din_o from the LSB side, so the first byte of a block ends up MSB.
//   Core    : after NBYTES data bytes a one-cycle start pulse is issued; the
//             core answers with core_done/core_dout.
//   Outbound: result bytes are returned MSB first on pad_a under host read
//             strobes (io_rd). pad_oen is only released after a turnaround gap
//             of TURN_CYC cycles of synchronised io_rd high.
//
// Optional feature macro: IO_PARITY_EN
//   Undefined: 8-bit pad bus, no parity logic.
//   Defined  : 9-bit pad bus, bit 8 is odd parity over bits 7:0. Inbound bytes
//              with bad parity are dropped and set err; pad_a[8] carries the
//              odd parity of pad_a[7:0].
//
// Ports
//   clk        in   core clock
//   rst_n      in   asynchronous active-low reset
//   pad_y      in   byte from data pads (+parity bit with IO_PARITY_EN)
//   pad_a      out  byte to data pads (+parity bit with IO_PARITY_EN)
//   pad_oen    out  data pad output enable, 1 = tri-stated
//   io_wr      in   host write strobe, asynchronous
//   io_rd      in   host read strobe, asynchronous
//   io_sel     in   1 = key byte, 0 = data byte, asynchronous
//   rdy_a      out  result-ready flag
//   err        out  sticky protocol/parity error, cleared by reset only
//   key_o      out  assembled key
//   din_o      out  assembled plaintext
//   start      out  one-cycle core start pulse
//   core_done  in   one-cycle core completion pulse
//   core_dout  in   core result, valid with core_done
// -----------------------------------------------------------------------------
module aes_pad_io_ctrl #(
  parameter int unsigned NBYTES      = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TURN_CYC    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef IO_PARITY_EN
  input  logic [8:0]            pad_y,
  output logic [8:0]            pad_a,
`else
  input  logic [7:0]            pad_y,
  output logic [7:0]            pad_a,
`endif
  output logic                  pad_oen,
  input  logic                  io_wr,
  input  logic                  io_rd,
  input  logic                  io_sel,
  output logic                  rdy_a,
  output logic                  err,
  output logic [8*NBYTES-1:0]   key_o,
  output logic [8*NBYTES-1:0]   din_o,
  output logic                  start,
  input  logic                  core_done,
  input  logic [8*NBYTES-1:0]   core_dout
);

  localparam int unsigned BlkW  = 8 * NBYTES;
  localparam int unsigned CntW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned TurnW = $clog2(TURN_CYC + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StBusy,
    StTurn,
    StDrive
  } state_e;

  state_e r_state, w_state_nxt;

  // Strobe synchronisers; the last stage is the synchronised strobe.
  logic [SYNC_STAGES-1:0] r_wr_sync, r_rd_sync, r_sel_sync;
  logic                   r_wr_prev, r_rd_prev;
  logic                   w_wr_s, w_rd_s, w_sel_s;
  logic                   w_wr_rise, w_rd_fall;

  logic [BlkW-1:0]  r_key, r_din, r_result;
  logic [CntW-1:0]  r_key_cnt, r_din_cnt, r_rd_idx;
  logic [TurnW-1:0] r_turn_cnt;
  logic             r_rdy, r_err;

  logic       w_oen;
  logic       w_par_ok;
  logic [7:0] w_byte, w_rd_byte;
  logic       w_in_idle, w_accept, w_key_wr, w_din_wr, w_din_last;
  logic       w_wr_err, w_done, w_turn_hit, w_drv_fall, w_last_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_sync  <= '0;
      r_rd_sync  <= '0;
      r_sel_sync <= '0;
      r_wr_prev  <= 1'b0;
      r_rd_prev  <= 1'b0;
    end else begin
      r_wr_sync  <= {r_wr_sync[SYNC_STAGES-2:0], io_wr};
      r_rd_sync  <= {r_rd_sync[SYNC_STAGES-2:0], io_rd};
      r_sel_sync <= {r_sel_sync[SYNC_STAGES-2:0], io_sel};
      r_wr_prev  <= w_wr_s;
      r_rd_prev  <= w_rd_s;
    end
  end

  assign w_wr_s    = r_wr_sync[SYNC_STAGES-1];
  assign w_rd_s    = r_rd_sync[SYNC_STAGES-1];
  assign w_sel_s   = r_sel_sync[SYNC_STAGES-1];
  assign w_wr_rise = w_wr_s & ~r_wr_prev;
  assign w_rd_fall = ~w_rd_s & r_rd_prev;

  // Bus is only driven in DRIVE; the read-strobe fall releases it in the same
  // cycle, before the state register leaves DRIVE. Reset forces IDLE, so the
  // pads tri-state asynchronously with rst_n.
  assign w_oen   = (r_state != StDrive) | w_rd_fall;
  assign pad_oen = w_oen;

  assign w_byte = pad_y[7:0];

`ifdef IO_PARITY_EN
  assign w_par_ok = ^pad_y;
  assign pad_a    = {~^w_rd_byte, w_rd_byte};
`else
  assign w_par_ok = 1'b1;
  assign pad_a    = w_rd_byte;
`endif

  // Inbound writes are only taken in IDLE; anything else is dropped.
  assign w_in_idle  = (r_state == StIdle);
  assign w_accept   = w_in_idle & w_wr_rise & w_par_ok;
  assign w_key_wr   = w_accept & w_sel_s;
  assign w_din_wr   = w_accept & ~w_sel_s;
  assign w_din_last = w_din_wr & (r_din_cnt == CntW'(NBYTES - 1));

  assign w_wr_err = w_wr_rise & ((r_state == StBusy) | ~w_oen | (w_in_idle & ~w_par_ok));

  assign w_done     = (r_state == StBusy) & core_done;
  assign w_turn_hit = (r_state == StTurn) & w_rd_s & (r_turn_cnt == TurnW'(TURN_CYC - 1));
  assign w_drv_fall = (r_state == StDrive) & w_rd_fall;
  assign w_last_rd  = w_drv_fall & (r_rd_idx == CntW'(NBYTES - 1));

  // Result byte selected by read index, MSB byte first.
  always_comb begin
    w_rd_byte = '0;
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (r_rd_idx == CntW'(i)) begin
        w_rd_byte = r_result[BlkW-1-8*i -: 8];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (w_din_last) w_state_nxt = StStart;
      StStart: w_state_nxt = StBusy;
      StBusy:  if (core_done) w_state_nxt = StTurn;
      StTurn:  if (w_turn_hit) w_state_nxt = StDrive;
      StDrive: begin
        if (w_rd_fall) w_state_nxt = w_last_rd ? StIdle : StTurn;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key      <= '0;
      r_din      <= '0;
      r_key_cnt  <= '0;
      r_din_cnt  <= '0;
      r_result   <= '0;
      r_rd_idx   <= '0;
      r_turn_cnt <= '0;
      r_rdy      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_key_wr) begin
        r_key     <= {r_key[BlkW-9:0], w_byte};
        r_key_cnt <= (r_key_cnt == CntW'(NBYTES - 1)) ? '0 : r_key_cnt + 1'b1;
      end
      if (w_din_wr) begin
        r_din     <= {r_din[BlkW-9:0], w_byte};
        r_din_cnt <= w_din_last ? '0 : r_din_cnt + 1'b1;
      end

      if (w_done) begin
        r_result <= core_dout;
      end

      if (w_done) begin
        r_rdy <= 1'b1;
      end else if (w_last_rd) begin
        r_rdy <= 1'b0;
      end

      if (w_drv_fall) begin
        r_rd_idx <= w_last_rd ? '0 : r_rd_idx + 1'b1;
      end

      // Turnaround counter only advances while the synced read strobe is held.
      if ((r_state == StTurn) && w_rd_s && !w_turn_hit) begin
        r_turn_cnt <= r_turn_cnt + 1'b1;
      end else begin
        r_turn_cnt <= '0;
      end

      if (w_wr_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign key_o = r_key;
  assign din_o = r_din;
  assign rdy_a = r_rdy;
  assign err   = r_err;
  assign start = (r_state == StStart);

endmodule

// File: tb/tb_aes_pad_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_pad_io_ctrl
//
// Self-checking bench for aes_pad_io_ctrl. A byte-level transaction model
// (key/data shift images, data count, block phase, sticky error) predicts
// every observed value. Stimulus mixes directed blocks with $urandom blocks.
// Honours IO_PARITY_EN for the pad bus width and parity checks.
// -----------------------------------------------------------------------------
module tb_aes_pad_io_ctrl;

  localparam int unsigned NB = 16;
  localparam int unsigned SS = 2;
  localparam int unsigned TC = 2;
  localparam int unsigned BW = 8 * NB;
`ifdef IO_PARITY_EN
  localparam int unsigned PW = 9;
`else
  localparam int unsigned PW = 8;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] pad_y = '0;
  logic [PW-1:0] pad_a;
  logic          pad_oen;
  logic          io_wr = 1'b0;
  logic          io_rd = 1'b0;
  logic          io_sel = 1'b0;
  logic          rdy_a, err, start;
  logic          core_done = 1'b0;
  logic [BW-1:0] key_o, din_o;
  logic [BW-1:0] core_dout = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_start = 0;

  // Transaction model. m_phase: 0 = accepting bytes, 1 = waiting for core,
  // 2 = result pending readout.
  logic [BW-1:0] m_key, m_din, m_res;
  int            m_din_cnt, m_rd_idx, m_starts, m_phase;
  bit            m_err;

  aes_pad_io_ctrl #(
    .NBYTES      (NB),
    .SYNC_STAGES (SS),
    .TURN_CYC    (TC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pad_y     (pad_y),
    .pad_a     (pad_a),
    .pad_oen   (pad_oen),
    .io_wr     (io_wr),
    .io_rd     (io_rd),
    .io_sel    (io_sel),
    .rdy_a     (rdy_a),
    .err       (err),
    .key_o     (key_o),
    .din_o     (din_o),
    .start     (start),
    .core_done (core_done),
    .core_dout (core_dout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start === 1'b1) n_start++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_key = '0; m_din = '0; m_res = '0;
    m_din_cnt = 0; m_rd_idx = 0; m_phase = 0; m_err = 1'b0;
  endfunction

  function automatic void m_write(input bit sel, input logic [7:0] b, input bit par_ok,
                                  input bit driven);
    if (driven || m_phase == 1) begin
      m_err = 1'b1;
    end else if (m_phase == 0) begin
      if (!par_ok) begin
        m_err = 1'b1;
      end else if (sel) begin
        m_key = {m_key[BW-9:0], b};
      end else begin
        m_din = {m_din[BW-9:0], b};
        m_din_cnt++;
        if (m_din_cnt == NB) begin
          m_din_cnt = 0;
          m_phase   = 1;
          m_starts++;
        end
      end
    end
  endfunction

  task automatic host_wr(input bit sel, input logic [7:0] b, input bit par);
    @(negedge clk);
    io_sel = sel;
`ifdef IO_PARITY_EN
    pad_y = {par, b};
`else
    pad_y = b;
    if (par) pad_y = b;
`endif
    io_wr = 1'b1;
    repeat (SS + 3) @(negedge clk);
    io_wr = 1'b0;
    repeat (SS + 3) @(negedge clk);
  endtask

  task automatic wr_chk(input bit sel, input logic [7:0] b, input bit good);
    bit par;
    par = good ? ~^b : ^b;
    host_wr(sel, b, par);
    m_write(sel, b, good, 1'b0);
    check("key_o", key_o, m_key);
    check("din_o", din_o, m_din);
    check("err", err, m_err);
    check("start_cnt", n_start, m_starts);
  endtask

  task automatic pulse_done(input logic [BW-1:0] d);
    @(negedge clk);
    core_dout = d;
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    @(negedge clk);
    if (m_phase == 1) begin
      m_res = d; m_phase = 2; m_rd_idx = 0;
    end
    check("rdy_after_done", rdy_a, m_phase == 2);
  endtask

  task automatic host_rd(input bit wr_in_drive);
    int         cyc;
    bit         seen;
    logic [7:0] eb;
    eb = m_res[BW-1-8*m_rd_idx -: 8];
    @(negedge clk);
    io_rd = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (pad_oen === 1'b0) seen = 1'b1;
    end
    check("oen_low", seen, 1'b1);
    check("turn_gap", cyc >= int'(SS + TC), 1'b1);
    if (wr_in_drive) begin
      host_wr(1'b1, 8'h5A, ~^8'h5A);
      m_write(1'b1, 8'h5A, 1'b1, 1'b1);
      check("oen_held", pad_oen, 1'b0);
      check("err_drive", err, m_err);
      check("key_drive", key_o, m_key);
      check("din_drive", din_o, m_din);
    end
    check("rd_byte", pad_a[7:0], eb);
`ifdef IO_PARITY_EN
    check("rd_par", pad_a[8], ~^eb);
`endif
    io_rd = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (pad_oen === 1'b1) seen = 1'b1;
    end
    check("oen_release", seen, 1'b1);
    m_rd_idx++;
    if (m_rd_idx == NB) begin
      m_rd_idx = 0; m_phase = 0;
    end
    repeat (2) @(negedge clk);
    check("rdy", rdy_a, m_phase == 2);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    io_wr = 1'b0; io_rd = 1'b0; core_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    check("err_after_rst", err, 1'b0);
  endtask

  initial begin
    logic [BW-1:0] rnd;
    int            guard;
    bit            oen_ok;
    bit            seen;
    m_reset();
    m_starts = 0;

    // Reset held: outputs stay at reset values whatever the inputs do.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rst_outs", {pad_oen, rdy_a, start, err}, 4'b1000);
      io_wr = 1'($urandom); io_rd = 1'($urandom); io_sel = 1'($urandom);
      pad_y = PW'($urandom); core_done = 1'($urandom);
      core_dout = {$urandom, $urandom, $urandom, $urandom};
    end
    check("rst_key", key_o, '0);
    check("rst_din", din_o, '0);
    check("rst_pad_a", pad_a, '0);
    @(negedge clk);
    io_wr = 1'b0; io_rd = 1'b0; io_sel = 1'b0; core_done = 1'b0;
    repeat (SS + 2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed block: key 00..0F, data 10..1F.
    for (int i = 0; i < 16; i++) wr_chk(1'b1, 8'(i), 1'b1);
    for (int i = 16; i < 32; i++) wr_chk(1'b0, 8'(i), 1'b1);
    check("key_known", key_o, 128'h000102030405060708090a0b0c0d0e0f);
    check("din_known", din_o, 128'h101112131415161718191a1b1c1d1e1f);
    check("one_start", n_start, 1);

    // Write while the core is busy: dropped, flags err.
    wr_chk(1'b1, 8'hEE, 1'b1);
    check("oen_busy", pad_oen, 1'b1);

    pulse_done({16{8'hA5}});
    for (int r = 0; r < NB; r++) host_rd(1'b0);

    // Fresh error state, then simultaneous write/read strobes in IDLE.
    do_reset();
    @(negedge clk);
    io_sel = 1'b1;
`ifdef IO_PARITY_EN
    pad_y = {~^8'h3C, 8'h3C};
`else
    pad_y = 8'h3C;
`endif
    io_wr = 1'b1; io_rd = 1'b1;
    oen_ok = 1'b1;
    repeat (SS + 3) begin
      @(negedge clk);
      if (pad_oen !== 1'b1) oen_ok = 1'b0;
    end
    io_wr = 1'b0; io_rd = 1'b0;
    repeat (SS + 3) begin
      @(negedge clk);
      if (pad_oen !== 1'b1) oen_ok = 1'b0;
    end
    m_write(1'b1, 8'h3C, 1'b1, 1'b0);
    check("simul_oen", oen_ok, 1'b1);
    check("simul_key", key_o, m_key);
    check("simul_rdy", rdy_a, 1'b0);

    // Randomised blocks; a stray core_done in IDLE must be ignored.
    for (int blk = 0; blk < 3; blk++) begin
      pulse_done({$urandom, $urandom, $urandom, $urandom});
      guard = 0;
      while (m_phase == 0 && guard < 200) begin
        wr_chk($urandom_range(0, 2) == 0, 8'($urandom), 1'b1);
        guard++;
      end
      pulse_done({$urandom, $urandom, $urandom, $urandom});
      for (int r = 0; r < NB; r++) host_rd(blk == 2 && r == 5);
    end

    // Reset while the pads are driven.
    do_reset();
    for (int i = 0; i < 16; i++) wr_chk(1'b0, 8'($urandom), 1'b1);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    pulse_done(rnd);
    @(negedge clk);
    io_rd = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (pad_oen === 1'b0) seen = 1'b1;
    end
    check("pre_rst_oen_low", seen, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_oen", pad_oen, 1'b1);
    check("async_rdy", rdy_a, 1'b0);
    check("async_key", key_o, '0);
    check("async_din", din_o, '0);
    io_rd = 1'b0;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SS + 2) @(negedge clk);
    wr_chk(1'b1, 8'hC3, 1'b1);
    check("idle_after_rst", key_o, {{(BW-8){1'b0}}, 8'hC3});

`ifdef IO_PARITY_EN
    do_reset();
    wr_chk(1'b1, 8'h01, 1'b0);
    wr_chk(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 16; i++) wr_chk(1'b0, 8'($urandom), 1'b1);
    pulse_done('0);
    host_rd(1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
